// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response layer.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } tx_state_t;

  localparam int FRAME_BYTES = 3;
  localparam int CMD_W       = 8 * FRAME_BYTES;

endpackage

// File: rtl/uart_resp_tx.sv
// Response launcher: latches one host byte, pulses trmt, then waits for a fresh tx_done.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send_resp,
  input  logic [7:0] resp_data,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       trmt,
  output logic       resp_busy,
  output logic [1:0] tx_state_dbg
);

  tx_state_t state, state_next;
  logic      first_wait;
  logic      load;
  logic      busy_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake: send_resp is sampled only in IDLE; tx_done is honoured only
  // from the second WAIT cycle on, so a stale level cannot end a new frame.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (send_resp) begin
          load       = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT;
      WAIT: begin
        if (!first_wait && tx_done) begin
          busy_clr   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data    <= 8'h00;
      resp_busy  <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      first_wait <= (state == LAUNCH);
      if (load) begin
        tx_data   <= resp_data;
        resp_busy <= 1'b1;
      end else if (busy_clr) begin
        resp_busy <= 1'b0;
      end
    end
  end

  assign trmt         = (state == LAUNCH);
  assign tx_state_dbg = state;

endmodule

// File: rtl/uart_cmd_if.sv
// UART command layer: assembles 3-byte frames into 24-bit commands and
// forwards 1-byte responses to the UART transmitter.
module uart_cmd_if
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int TO_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [7:0]       rx_data,
  output logic             clr_rdy,
  output logic [7:0]       tx_data,
  output logic             trmt,
  input  logic             tx_done,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             cmd_ovr,
  output logic             frame_err,
  input  logic             send_resp,
  input  logic [7:0]       resp_data,
  output logic             resp_busy,
  output logic [1:0]       rx_state_dbg,
  output logic [1:0]       tx_state_dbg
);

  rx_state_t rx_state, rx_next;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      b0, b1;
  logic            armed;
  logic            accept;
  logic            timeout;
  logic            complete;

  // A byte is taken once per rdy assertion: armed re-arms only after rdy drops,
  // so a UART that is slow to release rdy is never read twice.
  assign accept  = rdy && armed && !clr_rdy;
  assign timeout = (rx_state != B0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= B0;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next  = rx_state;
    complete = 1'b0;
    if (timeout) begin
      rx_next = accept ? B1 : B0;
    end else if (accept) begin
      case (rx_state)
        B0: rx_next = B1;
        B1: rx_next = B2;
        B2: begin
          rx_next  = B0;
          complete = 1'b1;
        end
        default: rx_next = B0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b1;
      clr_rdy   <= 1'b0;
      to_cnt    <= '0;
      b0        <= 8'h00;
      b1        <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      clr_rdy   <= accept;
      frame_err <= timeout;
      if (accept)    armed <= 1'b0;
      else if (!rdy) armed <= 1'b1;
      if (accept || timeout || rx_state == B0) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + 1'b1;
      if (accept && (timeout || rx_state == B0)) b0 <= rx_data;
      if (accept && !timeout && rx_state == B1)  b1 <= rx_data;
    end
  end

  // Completion has priority over the host acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      cmd_ovr <= 1'b0;
    end else if (complete) begin
      cmd     <= {b0, b1, rx_data};
      cmd_rdy <= 1'b1;
      if (cmd_rdy) cmd_ovr <= 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
      cmd_ovr <= 1'b0;
    end
  end

  assign rx_state_dbg = rx_state;

  uart_resp_tx u_resp_tx (
    .clk          (clk),
    .rst          (rst),
    .send_resp    (send_resp),
    .resp_data    (resp_data),
    .tx_done      (tx_done),
    .tx_data      (tx_data),
    .trmt         (trmt),
    .resp_busy    (resp_busy),
    .tx_state_dbg (tx_state_dbg)
  );

endmodule

// File: tb/tb_uart_cmd_if.sv
// Directed bench for uart_cmd_if: framing, timeout, overrun, response launch, reset.
module tb_uart_cmd_if;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_ovr;
  logic        frame_err;
  logic        send_resp;
  logic [7:0]  resp_data;
  logic        resp_busy;
  logic [1:0]  rx_state_dbg;
  logic [1:0]  tx_state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int ferr_cnt = 0;
  int trmt_cnt = 0;

  uart_cmd_if #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .rx_data      (rx_data),
    .clr_rdy      (clr_rdy),
    .tx_data      (tx_data),
    .trmt         (trmt),
    .tx_done      (tx_done),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .cmd_ovr      (cmd_ovr),
    .frame_err    (frame_err),
    .send_resp    (send_resp),
    .resp_data    (resp_data),
    .resp_busy    (resp_busy),
    .rx_state_dbg (rx_state_dbg),
    .tx_state_dbg (tx_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pulse monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (clr_rdy)   clr_cnt++;
    if (frame_err) ferr_cnt++;
    if (trmt)      trmt_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clr_rdy"},   32'(clr_rdy),   32'h0);
    chk({tag, "_trmt"},      32'(trmt),      32'h0);
    chk({tag, "_tx_data"},   32'(tx_data),   32'h0);
    chk({tag, "_cmd"},       32'(cmd),       32'h0);
    chk({tag, "_cmd_rdy"},   32'(cmd_rdy),   32'h0);
    chk({tag, "_cmd_ovr"},   32'(cmd_ovr),   32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_resp_busy"}, 32'(resp_busy), 32'h0);
    chk({tag, "_rx_state"},  32'(rx_state_dbg), 32'h0);
    chk({tag, "_tx_state"},  32'(tx_state_dbg), 32'h0);
  endtask

  // driver: present a byte until clr_rdy, then release rdy
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    rdy = 1'b1;
    rx_data = b;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (clr_rdy) got = 1'b1;
    end
    chk("clr_rdy_seen", 32'(got), 32'h1);
    rdy = 1'b0;
    tick();
  endtask

  task automatic host_ack();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    int c0;
    int f0;
    logic seen;
    rst = 1'b1;
    rdy = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    resp_data = 8'h00;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: basic frame A5 12 34
    c0 = clr_cnt;
    send_byte(8'hA5);
    chk("t1_state_b1", 32'(rx_state_dbg), 32'h1);
    send_byte(8'h12);
    chk("t1_state_b2", 32'(rx_state_dbg), 32'h2);
    rdy = 1'b1;
    rx_data = 8'h34;
    chk("t1_cmd_rdy_before", 32'(cmd_rdy), 32'h0);
    tick();
    chk("t1_clr_rdy", 32'(clr_rdy), 32'h1);
    chk("t1_cmd_rdy_lat1", 32'(cmd_rdy), 32'h1);
    chk("t1_cmd", 32'(cmd), 32'h00A51234);
    rdy = 1'b0;
    tick();
    chk("t1_clr_pulses", 32'(clr_cnt - c0), 32'd3);
    host_ack();
    chk("t1_cmd_rdy_cleared", 32'(cmd_rdy), 32'h0);

    // 2: rdy held for 3 cycles
    c0 = clr_cnt;
    rdy = 1'b1;
    rx_data = 8'h77;
    repeat (3) tick();
    rdy = 1'b0;
    repeat (2) tick();
    chk("t2_single_accept", 32'(clr_cnt - c0), 32'd1);
    chk("t2_state_b1", 32'(rx_state_dbg), 32'h1);
    f0 = ferr_cnt;
    repeat (TO + 4) tick();
    chk("t2_timeout_err", 32'(ferr_cnt - f0), 32'd1);
    chk("t2_state_b0", 32'(rx_state_dbg), 32'h0);

    // 3: timeout after two bytes, then a clean frame
    f0 = ferr_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    seen = 1'b0;
    for (int i = 0; i < 3 * TO && !seen; i++) begin
      tick();
      if (frame_err) seen = 1'b1;
    end
    chk("t3_frame_err_seen", 32'(seen), 32'h1);
    repeat (4) tick();
    chk("t3_frame_err_once", 32'(ferr_cnt - f0), 32'd1);
    chk("t3_state_b0", 32'(rx_state_dbg), 32'h0);
    chk("t3_cmd_untouched", 32'(cmd), 32'h00A51234);
    chk("t3_cmd_rdy_untouched", 32'(cmd_rdy), 32'h0);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h0C);
    chk("t3_cmd", 32'(cmd), 32'h000A0B0C);
    chk("t3_cmd_rdy", 32'(cmd_rdy), 32'h1);
    chk("t3_no_extra_err", 32'(ferr_cnt - f0), 32'd1);

    // 4: overrun and acknowledge priority
    host_ack();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("t4_ovr_first", 32'(cmd_ovr), 32'h0);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    chk("t4_cmd_second", 32'(cmd), 32'h00445566);
    chk("t4_ovr_set", 32'(cmd_ovr), 32'h1);
    host_ack();
    chk("t4_rdy_clr", 32'(cmd_rdy), 32'h0);
    chk("t4_ovr_clr", 32'(cmd_ovr), 32'h0);
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    send_byte(8'hAA); send_byte(8'hBB);
    rdy = 1'b1;
    rx_data = 8'hCC;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("t4_coinc_rdy", 32'(cmd_rdy), 32'h1);
    chk("t4_coinc_cmd", 32'(cmd), 32'h00AABBCC);
    chk("t4_coinc_ovr", 32'(cmd_ovr), 32'h1);
    rdy = 1'b0;
    tick();
    host_ack();
    chk("t4_final_rdy", 32'(cmd_rdy), 32'h0);
    chk("t4_final_ovr", 32'(cmd_ovr), 32'h0);

    // 5: response with stale tx_done
    c0 = trmt_cnt;
    tx_done = 1'b1;
    send_resp = 1'b1;
    resp_data = 8'h5A;
    tick();
    chk("t5_trmt", 32'(trmt), 32'h1);
    chk("t5_busy", 32'(resp_busy), 32'h1);
    chk("t5_tx_data", 32'(tx_data), 32'h5A);
    resp_data = 8'hC3;
    tick();
    chk("t5_trmt_once", 32'(trmt), 32'h0);
    tick();
    chk("t5_busy_stale_done", 32'(resp_busy), 32'h1);
    send_resp = 1'b0;
    tx_done = 1'b0;
    repeat (3) tick();
    chk("t5_busy_waiting", 32'(resp_busy), 32'h1);
    chk("t5_data_held", 32'(tx_data), 32'h5A);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_busy_done", 32'(resp_busy), 32'h0);
    chk("t5_tx_idle", 32'(tx_state_dbg), 32'h0);
    repeat (2) tick();
    chk("t5_trmt_count", 32'(trmt_cnt - c0), 32'd1);
    chk("t5_data_final", 32'(tx_data), 32'h5A);

    // 6: reset mid-frame and mid-transmission
    send_byte(8'h01);
    send_byte(8'h02);
    send_resp = 1'b1;
    resp_data = 8'h7E;
    tick();
    send_resp = 1'b0;
    tick();
    chk("t6_in_b2", 32'(rx_state_dbg), 32'h2);
    chk("t6_in_wait", 32'(tx_state_dbg), 32'h2);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_reset");
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h0D); send_byte(8'h0E); send_byte(8'h0F);
    chk("t6_clean_cmd", 32'(cmd), 32'h000D0E0F);
    chk("t6_clean_rdy", 32'(cmd_rdy), 32'h1);
    chk("t6_no_ovr", 32'(cmd_ovr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
